// File: rtl/mc_main_fsm_pkg.sv
// mc_pkg: state encoding, opcodes and datapath select codes shared by control and datapath.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_JAL,
        S_ALUWB,
        S_BEQ,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_main_fsm_if.sv
// mc_main_fsm_if: opcode in, datapath enables and selects out of the main control FSM.
interface mc_main_fsm_if;
    logic [6:0] i_OpCode;
    logic       o_PCUpdate;
    logic       o_Branch;
    logic       o_IRWrite;
    logic       o_AdrSrc;
    logic       o_MemWrite;
    logic       o_RegWrite;
    logic [1:0] o_ResultSrc;
    logic [1:0] o_ALUSrcA;
    logic [1:0] o_ALUSrcB;
    logic [1:0] o_ALUOp;
    logic       o_Retire;
    logic       o_Illegal;

    modport master (
        input  i_OpCode,
        output o_PCUpdate, o_Branch, o_IRWrite, o_AdrSrc, o_MemWrite, o_RegWrite,
               o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ALUOp, o_Retire, o_Illegal
    );

    modport slave (
        output i_OpCode,
        input  o_PCUpdate, o_Branch, o_IRWrite, o_AdrSrc, o_MemWrite, o_RegWrite,
               o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ALUOp, o_Retire, o_Illegal
    );
endinterface

// File: rtl/mc_main_fsm.sv
// mc_main_fsm: multi-cycle RV32I main control FSM with Moore datapath controls.
module mc_main_fsm
    import mc_pkg::*;
(
    input logic           i_Clk,
    input logic           i_Reset,
    mc_main_fsm_if.master bus
);

    state_t     state_q, state_d;
    logic [6:0] op;

    assign op = bus.i_OpCode;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    // Unused encodings fall through to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:  state_d = (op == OP_LOAD || op == OP_STORE) ? S_MEMADR :
                                 (op == OP_R)   ? S_EXECR :
                                 (op == OP_I)   ? S_EXECI :
                                 (op == OP_JAL) ? S_JAL   :
                                 (op == OP_BEQ) ? S_BEQ   : S_TRAP;
            S_MEMADR:  state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_FETCH;
        endcase
    end

    // Reset masks every control so nothing is written while reset is held.
    always_comb begin
        bus.o_PCUpdate  = 1'b0;
        bus.o_Branch    = 1'b0;
        bus.o_IRWrite   = 1'b0;
        bus.o_AdrSrc    = 1'b0;
        bus.o_MemWrite  = 1'b0;
        bus.o_RegWrite  = 1'b0;
        bus.o_ResultSrc = RES_ALUOUT;
        bus.o_ALUSrcA   = SRCA_PC;
        bus.o_ALUSrcB   = SRCB_RS2;
        bus.o_ALUOp     = ALUOP_ADD;
        bus.o_Retire    = 1'b0;
        bus.o_Illegal   = 1'b0;
        if (!i_Reset) begin
            case (state_q)
                S_FETCH: begin
                    bus.o_IRWrite   = 1'b1;
                    bus.o_ALUSrcB   = SRCB_FOUR;
                    bus.o_ResultSrc = RES_ALURESULT;
                    bus.o_PCUpdate  = 1'b1;
                end
                S_DECODE: begin
                    bus.o_ALUSrcA = SRCA_OLDPC;
                    bus.o_ALUSrcB = SRCB_IMM;
                end
                S_MEMADR: begin
                    bus.o_ALUSrcA = SRCA_RS1;
                    bus.o_ALUSrcB = SRCB_IMM;
                end
                S_MEMREAD: bus.o_AdrSrc = 1'b1;
                S_MEMWB: begin
                    bus.o_ResultSrc = RES_DATA;
                    bus.o_RegWrite  = 1'b1;
                    bus.o_Retire    = 1'b1;
                end
                S_MEMWRITE: begin
                    bus.o_AdrSrc   = 1'b1;
                    bus.o_MemWrite = 1'b1;
                    bus.o_Retire   = 1'b1;
                end
                S_EXECR: begin
                    bus.o_ALUSrcA = SRCA_RS1;
                    bus.o_ALUOp   = ALUOP_FUNCT;
                end
                S_EXECI: begin
                    bus.o_ALUSrcA = SRCA_RS1;
                    bus.o_ALUSrcB = SRCB_IMM;
                    bus.o_ALUOp   = ALUOP_FUNCT;
                end
                S_JAL: begin
                    bus.o_ALUSrcA  = SRCA_OLDPC;
                    bus.o_ALUSrcB  = SRCB_FOUR;
                    bus.o_PCUpdate = 1'b1;
                end
                S_ALUWB: begin
                    bus.o_RegWrite = 1'b1;
                    bus.o_Retire   = 1'b1;
                end
                S_BEQ: begin
                    bus.o_ALUSrcA = SRCA_RS1;
                    bus.o_ALUOp   = ALUOP_SUB;
                    bus.o_Branch  = 1'b1;
                    bus.o_Retire  = 1'b1;
                end
                S_TRAP:  bus.o_Illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_main_fsm.sv
// tb_mc_main_fsm: directed per-cycle check of the packed control word against hand-derived values.
module tb_mc_main_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    mc_main_fsm_if bus ();

    mc_main_fsm dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // {PCUpdate,Branch,IRWrite,AdrSrc,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,Retire,Illegal}
    logic [15:0] ctl;
    assign ctl = {bus.o_PCUpdate, bus.o_Branch, bus.o_IRWrite, bus.o_AdrSrc, bus.o_MemWrite,
                  bus.o_RegWrite, bus.o_ResultSrc, bus.o_ALUSrcA, bus.o_ALUSrcB, bus.o_ALUOp,
                  bus.o_Retire, bus.o_Illegal};

    localparam logic [15:0] E_ZERO   = 16'h0000;
    localparam logic [15:0] E_FETCH  = 16'hA220;
    localparam logic [15:0] E_DECODE = 16'h0050;
    localparam logic [15:0] E_MEMADR = 16'h0090;
    localparam logic [15:0] E_MEMRD  = 16'h1000;
    localparam logic [15:0] E_MEMWB  = 16'h0502;
    localparam logic [15:0] E_MEMWR  = 16'h1802;
    localparam logic [15:0] E_EXECR  = 16'h0088;
    localparam logic [15:0] E_EXECI  = 16'h0098;
    localparam logic [15:0] E_JAL    = 16'h8060;
    localparam logic [15:0] E_ALUWB  = 16'h0402;
    localparam logic [15:0] E_BEQ    = 16'h4086;
    localparam logic [15:0] E_TRAP   = 16'h0001;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %04h expected %04h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [6:0] op, input int n,
                       input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                       input logic [15:0] e3, input logic [15:0] e4);
        logic [15:0] e [5];
        e = '{e0, e1, e2, e3, e4};
        bus.i_OpCode = op;
        #1;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_c%0d", tag, i + 1), ctl, e[i]);
            step();
        end
    endtask

    initial begin
        bus.i_OpCode = 7'b0110011;
        #1;
        check("rst_t0", ctl, E_ZERO);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_c%0d", i + 1), ctl, E_ZERO);
        end
        rst = 1'b0;
        #1;
        check("first_fetch", ctl, E_FETCH);

        run("lw",   7'b0000011, 5, E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB);
        run("sw",   7'b0100011, 4, E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_ZERO);
        run("rtyp", 7'b0110011, 4, E_FETCH, E_DECODE, E_EXECR,  E_ALUWB, E_ZERO);
        run("ityp", 7'b0010011, 4, E_FETCH, E_DECODE, E_EXECI,  E_ALUWB, E_ZERO);
        run("beq",  7'b1100011, 3, E_FETCH, E_DECODE, E_BEQ,    E_ZERO,  E_ZERO);
        run("jal",  7'b1101111, 4, E_FETCH, E_DECODE, E_JAL,    E_ALUWB, E_ZERO);

        run("ill", 7'b1110011, 3, E_FETCH, E_DECODE, E_TRAP, E_ZERO, E_ZERO);
        for (int i = 0; i < 20; i++) begin
            bus.i_OpCode = (i % 2 == 0) ? 7'b0000011 : 7'($urandom_range(0, 127));
            step();
            check($sformatf("trap_hold%0d", i), ctl, E_TRAP);
        end
        rst = 1'b1;
        #1;
        check("trap_rst", ctl, E_ZERO);
        step();
        rst = 1'b0;
        #1;
        check("trap_exit", ctl, E_FETCH);

        run("lw_mid", 7'b0000011, 3, E_FETCH, E_DECODE, E_MEMADR, E_ZERO, E_ZERO);
        check("mid_memrd", ctl, E_MEMRD);
        rst = 1'b1;
        #1;
        check("mid_rst", ctl, E_ZERO);
        step();
        check("mid_rst_hold", ctl, E_ZERO);
        rst = 1'b0;
        #1;
        run("after_mid", 7'b0100011, 4, E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_ZERO);
        check("final_fetch", ctl, E_FETCH);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_main_fsm.md
# mc_main_fsm

Main control state machine for the multi-cycle RV32I processor. It sits upstream of the datapath inside the control unit. From the instruction register's opcode it sequences every instruction through Fetch, Decode, Execute, Memory and Writeback. It drives the datapath enables and mux selects as Moore outputs. The ALU decoder and the immediate-type decoder stay combinational and separate. The surrounding logic forms `PCWrite = o_PCUpdate | (o_Branch & Zero)`.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- `i_Clk`  in  1  system clock; one clock domain; all state changes on the rising edge.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_OpCode`  in  7  instruction[6:0] from the instruction register; valid from Decode onward.
- `o_PCUpdate`  out  1  unconditional PC write.
- `o_Branch`  out  1  conditional PC write; qualified by Zero outside this block.
- `o_IRWrite`  out  1  instruction register load.
- `o_AdrSrc`  out  1  memory address select: 0 = PC, 1 = Result.
- `o_MemWrite`  out  1  memory write strobe.
- `o_RegWrite`  out  1  register file write.
- `o_ResultSrc`  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `o_ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register.
- `o_ALUSrcB`  out  2  ALU B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- `o_ALUOp`  out  2  00 = add, 01 = subtract, 10 = funct-decoded.
- `o_Retire`  out  1  one-cycle pulse in the final state of each instruction.
- `o_Illegal`  out  1  high while in the trap state.

## Operation
Every output not listed for a state is 0.

- **FETCH**: `o_AdrSrc`=0, `o_IRWrite`=1, `o_ALUSrcA`=00, `o_ALUSrcB`=10, `o_ALUOp`=00, `o_ResultSrc`=10, `o_PCUpdate`=1. Next state: DECODE.
- **DECODE**: `o_ALUSrcA`=01, `o_ALUSrcB`=01, `o_ALUOp`=00; this precomputes the branch/jump target. Next state depends on `i_OpCode`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - anything else → TRAP
- **MEMADR**: `o_ALUSrcA`=10, `o_ALUSrcB`=01, `o_ALUOp`=00. Next: MEMREAD if opcode is 0000011, else MEMWRITE.
- **MEMREAD**: `o_ResultSrc`=00, `o_AdrSrc`=1. Next: MEMWB.
- **MEMWB**: `o_ResultSrc`=01, `o_RegWrite`=1, `o_Retire`=1. Next: FETCH.
- **MEMWRITE**: `o_ResultSrc`=00, `o_AdrSrc`=1, `o_MemWrite`=1, `o_Retire`=1. Next: FETCH.
- **EXECR**: `o_ALUSrcA`=10, `o_ALUSrcB`=00, `o_ALUOp`=10. Next: ALUWB.
- **EXECI**: `o_ALUSrcA`=10, `o_ALUSrcB`=01, `o_ALUOp`=10. Next: ALUWB.
- **JAL**: `o_ALUSrcA`=01, `o_ALUSrcB`=10, `o_ALUOp`=00, `o_ResultSrc`=00, `o_PCUpdate`=1. Next: ALUWB.
- **ALUWB**: `o_ResultSrc`=00, `o_RegWrite`=1, `o_Retire`=1. Next: FETCH.
- **BEQ**: `o_ALUSrcA`=10, `o_ALUSrcB`=00, `o_ALUOp`=01, `o_ResultSrc`=00, `o_Branch`=1, `o_Retire`=1. Next: FETCH.
- **TRAP**: `o_Illegal`=1, all other outputs 0. Holds until reset.

Opcode handling:
- `i_OpCode` is sampled only in DECODE and MEMADR.
- Its value in every other state is ignored.

## Timing
- State register updates on the rising edge of `i_Clk`. Outputs decode combinationally from the state register only (pure Moore).
- Reset:
  - While `i_Reset`=1, every output is forced to 0, including FETCH's `o_IRWrite` and `o_PCUpdate`.
  - On each reset edge the state loads FETCH.
  - The first fetch occurs in the first cycle after `i_Reset` deasserts.
- Reset mid-instruction: the next cycle is FETCH, with no partial writeback and no `o_MemWrite`.
- Cycles per instruction, FETCH to last state inclusive:
  - lw: 5
  - sw, R-type, I-type ALU, jal: 4
  - beq: 3
- Exactly one `o_Retire` pulse per instruction. It coincides with the cycle of the instruction's architectural write.
- At most one of `o_RegWrite` and `o_MemWrite` is high in any cycle.
- Unreachable state encodings must recover to FETCH on the next edge.

## Structure
- Shared package `mc_pkg` holds:
  - `state_t` enum (12 states, 4-bit encoding)
  - opcode constants: `OP_LOAD`, `OP_STORE`, `OP_R`, `OP_I`, `OP_JAL`, `OP_BEQ`
  - ResultSrc, ALUSrcA, ALUSrcB and ALUOp select constants, which the datapath muxes also import
- Single flat module: one `always_ff` for the state register, one `always_comb` for next state, one `always_comb` for outputs. No sub-module.

## Test plan
- **Reset**: hold `i_Reset`=1 for 3 cycles with `i_OpCode`=0110011 → all outputs 0 throughout. First cycle after release is FETCH with `o_IRWrite`=1 and `o_PCUpdate`=1.
- **lw then sw**: opcode 0000011 → FETCH, DECODE, MEMADR, MEMREAD, MEMWB; `o_RegWrite`=1 and `o_Retire`=1 only in cycle 5. Then 0100011 → `o_MemWrite`=1 only in cycle 4, `o_RegWrite` never high.
- **R-type and I-type**: 0110011 → EXECR shows `o_ALUSrcB`=00, `o_ALUOp`=10. 0010011 → EXECI shows `o_ALUSrcB`=01. Both retire in ALUWB in cycle 4.
- **Branch and jump**: 1100011 → `o_Branch`=1, `o_ALUOp`=01 in cycle 3, next cycle FETCH. 1101111 → `o_PCUpdate`=1 in cycle 3, `o_RegWrite`=1 in cycle 4.
- **Illegal opcode**: 1110011 → `o_Illegal`=1 from cycle 3 and held for 20 cycles regardless of `i_OpCode`. Asserting `i_Reset` returns to FETCH.
- **Mid-instruction reset**: assert `i_Reset` during MEMREAD of a lw → `o_RegWrite` is never asserted for that lw, and FETCH follows the release.
